// File: rtl/dt_coef_gen.sv
// Time-coefficient generator: turns one sampled dt into delta_t, dt^2/2, dt^3/6, 5*dt^4/12 and dt^5/12.
// All products come from one shared, externally supplied multiplier, driven one operation at a time.
module dt_coef_gen #(
    parameter int DBL_WIDTH   = 64,
    parameter int TIMEOUT_CYC = 64,
    parameter bit CACHE_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dt_valid,
    input  logic [DBL_WIDTH-1:0] dt_in,
    output logic                 dt_ready,
    output logic [DBL_WIDTH-1:0] delta_t,
    output logic [DBL_WIDTH-1:0] half_dt2,
    output logic [DBL_WIDTH-1:0] sixth_dt3,
    output logic [DBL_WIDTH-1:0] five12_dt4,
    output logic [DBL_WIDTH-1:0] one12_dt5,
    output logic                 coef_valid,
    output logic                 coef_done,
    output logic                 err_timeout,
    output logic                 mul_valid,
    output logic [DBL_WIDTH-1:0] mul_a,
    output logic [DBL_WIDTH-1:0] mul_b,
    input  logic                 mul_finish,
    input  logic [DBL_WIDTH-1:0] mul_result,
    output logic [1:0]           dbg_state
);

    // Handshakes: dt is taken on a rising edge where dt_valid & dt_ready; mul_valid is a
    // single-cycle request, and mul_finish/mul_result are honoured only while waiting on it.

    localparam logic [DBL_WIDTH-1:0] K_HALF   = 64'h3FE0000000000000;
    localparam logic [DBL_WIDTH-1:0] K_SIXTH  = 64'h3FC5555555555555;
    localparam logic [DBL_WIDTH-1:0] K_FIVE12 = 64'h3FDAAAAAAAAAAAAB;
    localparam logic [DBL_WIDTH-1:0] K_ONE12  = 64'h3FB5555555555555;
    localparam int                   CW       = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q;
    logic [CW-1:0]        wait_cnt_q;
    logic [DBL_WIDTH-1:0] dt_q;
    logic [DBL_WIDTH-1:0] p2_q, p3_q, p4_q, p5_q;
    logic [DBL_WIDTH-1:0] c2_q, c3_q, c4_q, c5_q;
    logic                 accept;
    logic                 cache_hit;
    logic                 capture;
    logic                 timeout;

    assign dbg_state = state_q;

    // Operand selection depends only on the op index, so it is stable across ISSUE.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (op_q)
            4'd0: begin mul_a = dt_q; mul_b = dt_q;     end
            4'd1: begin mul_a = p2_q; mul_b = dt_q;     end
            4'd2: begin mul_a = p3_q; mul_b = dt_q;     end
            4'd3: begin mul_a = p4_q; mul_b = dt_q;     end
            4'd4: begin mul_a = p2_q; mul_b = K_HALF;   end
            4'd5: begin mul_a = p3_q; mul_b = K_SIXTH;  end
            4'd6: begin mul_a = p4_q; mul_b = K_FIVE12; end
            4'd7: begin mul_a = p5_q; mul_b = K_ONE12;  end
            default: begin mul_a = '0; mul_b = '0;      end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        dt_ready  = (state_q == S_IDLE);
        mul_valid = 1'b0;
        accept    = 1'b0;
        cache_hit = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dt_valid) begin
                    if (CACHE_EN && coef_valid && (dt_in == delta_t)) begin
                        cache_hit = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mul_valid = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (mul_finish) begin
                    capture = 1'b1;
                    state_d = (op_q == 4'd7) ? S_PUBLISH : S_ISSUE;
                end else if (wait_cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            wait_cnt_q <= '0;
            dt_q       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dt_q <= dt_in;
                op_q <= '0;
            end else if (capture) begin
                op_q <= op_q + 4'd1;
            end
            if (state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q + CW'(1);
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    // Partial powers and scaled coefficients, one register per op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p2_q <= '0; p3_q <= '0; p4_q <= '0; p5_q <= '0;
            c2_q <= '0; c3_q <= '0; c4_q <= '0; c5_q <= '0;
        end else if (capture) begin
            case (op_q)
                4'd0: p2_q <= mul_result;
                4'd1: p3_q <= mul_result;
                4'd2: p4_q <= mul_result;
                4'd3: p5_q <= mul_result;
                4'd4: c2_q <= mul_result;
                4'd5: c3_q <= mul_result;
                4'd6: c4_q <= mul_result;
                4'd7: c5_q <= mul_result;
                default: ;
            endcase
        end
    end

    // The published set only moves in PUBLISH, so consumers see the old set during a recompute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delta_t     <= '0;
            half_dt2    <= '0;
            sixth_dt3   <= '0;
            five12_dt4  <= '0;
            one12_dt5   <= '0;
            coef_valid  <= 1'b0;
            coef_done   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            coef_done <= cache_hit;
            if (accept) begin
                coef_valid  <= 1'b0;
                err_timeout <= 1'b0;
            end
            if (timeout) begin
                err_timeout <= 1'b1;
            end
            if (state_q == S_PUBLISH) begin
                delta_t    <= dt_q;
                half_dt2   <= c2_q;
                sixth_dt3  <= c3_q;
                five12_dt4 <= c4_q;
                one12_dt5  <= c5_q;
                coef_valid <= 1'b1;
                coef_done  <= 1'b1;
            end
        end
    end

endmodule
